// File: rtl/toggle_event_decoder.sv
// Turns an asynchronous toggle-encoded line into one-cycle event pulses, with a wrapping event
// count and a saturating pending counter drained by valid/ready. Macro: TOGGLE_GLITCH_FILTER_EN.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    output logic              ev_pulse,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CNT_W-1:0]  ev_count,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

`ifdef TOGGLE_GLITCH_FILTER_EN
    localparam int ARM_CYC = SYNC_STAGES + 2;
`else
    localparam int ARM_CYC = SYNC_STAGES + 1;
`endif
    localparam int AW = $clog2(ARM_CYC + 1);

    typedef enum logic {ARM, RUN} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          arm_cnt, arm_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   tog_s;
    logic                   tog_d;
    logic                   det;
    logic                   pop;

    assign tog_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tog_in};
        end
    end

`ifdef TOGGLE_GLITCH_FILTER_EN
    logic tog_f;
    logic stable;

    // tog_d only follows a level that tog_s has shown on two consecutive cycles
    assign stable = (tog_s == tog_f);
    assign det    = stable & (tog_s ^ tog_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_f <= 1'b0;
            tog_d <= 1'b0;
        end else begin
            tog_f <= tog_s;
            if (stable) begin
                tog_d <= tog_s;
            end
        end
    end
`else
    assign det = tog_s ^ tog_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_d <= 1'b0;
        end else begin
            tog_d <= tog_s;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARM;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

    // ARM masks the edge seen when tog_in is already high at reset release
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        case (state)
            ARM: begin
                arm_cnt_nxt = arm_cnt + AW'(1);
                if (arm_cnt == AW'(ARM_CYC - 1)) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign ev_valid = (pend != '0);
    assign pop      = ev_valid & ev_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_pulse <= 1'b0;
            ev_count <= '0;
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            ev_pulse <= det & (state == RUN);
            if (ev_pulse) begin
                ev_count <= ev_count + CNT_W'(1);
            end
            if (ev_pulse && !pop) begin
                if (&pend) begin
                    overflow <= 1'b1;
                end else begin
                    pend <= pend + PEND_W'(1);
                end
            end else if (!ev_pulse && pop) begin
                pend <= pend - PEND_W'(1);
            end
        end
    end

endmodule
